frame_gather: RTL and testbench
===============================

FRAME_GATHER -- requirements
Module: frame_gather

Interface
REQ-001 SHALL have parameter N_PTS, default 8, samples per frame (power of 2, 2..64).
REQ-002 SHALL have parameter IN_W, default 24, signed input component width.
REQ-003 SHALL have parameter OUT_W, default 24, signed output component width (OUT_W >= IN_W).
REQ-004 SHALL have parameter SHIFT, default 12, left-shift scaling applied per component.
REQ-005 SHALL have parameter BITREV, default 0, 1 = place samples in bit-reversed index order.
REQ-006 SHALL have port clk, input, 1, single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have ports in_x / in_y, input, IN_W each, signed real / imag sample.
REQ-009 SHALL have port in_valid, input, 1, sample present.
REQ-010 SHALL have port in_sof, input, 1, sample is index 0 of a frame; qualified by in_valid.
REQ-011 SHALL have port in_ready, output, 1, sample accepted when in_valid && in_ready.
REQ-012 SHALL have ports frame_real / frame_imag, output, N_PTS*OUT_W each; slot k at bits [k*OUT_W +: OUT_W].
REQ-013 SHALL have port out_valid, output, 1, complete frame held on frame_real/imag.
REQ-014 SHALL have port out_ready, input, 1, frame consumed when out_valid && out_ready.
REQ-015 SHALL have ports sat_pulse, sof_err, output, 1 each, one-cycle status pulses.
REQ-016 SHALL have port frame_cnt, output, 16, count of frames delivered to the hold register, wrapping.

Function
REQ-017 SHALL keep a fill buffer (N_PTS complex entries), a hold register driving frame_real/imag, and a write index widx (log2 N_PTS bits).
REQ-018 Each accepted component SHALL be computed as (in << SHIFT) sign-extended to OUT_W and saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-019 sat_pulse SHALL be high for one cycle after any accepted sample with either component saturated.
REQ-020 Slot address SHALL be widx when BITREV=0, and widx bit-reversed over log2 N_PTS bits when BITREV=1.
REQ-021 widx SHALL increment on each accepted sample and wrap from N_PTS-1 to 0.
REQ-022 An accepted sample with in_sof=1 SHALL be written at index 0, with widx becoming 1 on that edge.
REQ-023 If in_sof=1 arrives while widx!=0, the partial frame SHALL be discarded, sof_err SHALL pulse for one cycle, and frame_cnt SHALL be unchanged.
REQ-024 A sample accepted with in_sof=0 while widx=0 SHALL start a frame normally (no sync required).
REQ-025 On the edge accepting sample N_PTS-1, the complete frame SHALL load into the hold register, out_valid SHALL rise, and frame_cnt SHALL increment.
REQ-026 out_valid SHALL fall on the edge where out_valid && out_ready, unless a new frame loads on that same edge, in which case out_valid stays 1.
REQ-027 Hold contents SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 in_ready SHALL be 0 only when widx=N_PTS-1 and out_valid=1 and out_ready=0 (combinational from out_ready), and 1 otherwise.
REQ-029 Hold contents after consumption SHALL remain unchanged (no clearing); only out_valid falls.

Reset
REQ-030 While reset=1: widx=0, fill buffer and hold all zero, out_valid=0, sat_pulse=0, sof_err=0, frame_cnt=0; in_ready=1 after release.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame and any held frame without raising sof_err.

Verification (N_PTS=8, IN_W=OUT_W=24, SHIFT=12)
REQ-032 in_sof on first sample, in_x=k+1, in_y=-(k+1) for k=0..7, out_ready=1 -> out_valid for 1 cycle after 8th accept, slot k = 4096*(k+1) / -4096*(k+1), frame_cnt=1.
REQ-033 in_x=2048, in_y=-2048 -> component 8388607 (saturated) and -8388608, sat_pulse=1 for one cycle.
REQ-034 out_ready=0, 16 continuous samples -> first frame held unchanged, in_ready=0 at the 16th sample; after out_ready=1 -> second frame loads with no lost sample.
REQ-035 in_sof after 3 samples -> sof_err pulse, next frame completes 8 samples later, frame_cnt +1 only.
REQ-036 BITREV=1, samples 0..7 -> slot order 0,4,2,6,1,5,3,7.
REQ-037 reset after 5 samples -> outputs zero, out_valid=0, next 8 samples form a clean frame.

Source files
------------

// File: rtl/frame_gather.sv
// frame_gather: collects N_PTS complex samples into a fill buffer, scales and
// saturates each component, and hands complete frames to a hold register.
module frame_gather #(
    parameter int N_PTS  = 8,
    parameter int IN_W   = 24,
    parameter int OUT_W  = 24,
    parameter int SHIFT  = 12,
    parameter int BITREV = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [IN_W-1:0]   in_x,
    input  logic signed [IN_W-1:0]   in_y,
    input  logic                     in_valid,
    input  logic                     in_sof,
    output logic                     in_ready,
    output logic [N_PTS*OUT_W-1:0]   frame_real,
    output logic [N_PTS*OUT_W-1:0]   frame_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_pulse,
    output logic                     sof_err,
    output logic [15:0]              frame_cnt
);

    localparam int AW = $clog2(N_PTS);
    localparam int EW = (IN_W + SHIFT > OUT_W) ? (IN_W + SHIFT) : OUT_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_PTS - 1);

    // Returns {saturated, value}; the value is clamped when the bits above the
    // OUT_W sign bit disagree with it.
    function automatic logic [OUT_W:0] scale_sat(input logic signed [IN_W-1:0] v);
        logic signed [EW-1:0] ext;
        logic [EW-OUT_W:0]    top;
        ext = EW'(v);
        ext = ext <<< SHIFT;
        top = ext[EW-1:OUT_W-1];
        if ((&top) || !(|top)) begin
            scale_sat = {1'b0, ext[OUT_W-1:0]};
        end else if (ext[EW-1]) begin
            scale_sat = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            scale_sat = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] a);
        for (int i = 0; i < AW; i++) begin
            bit_rev[i] = a[AW-1-i];
        end
    endfunction

    logic [AW-1:0]                  widx_r;
    logic [N_PTS-1:0][OUT_W-1:0]    fill_re_r;
    logic [N_PTS-1:0][OUT_W-1:0]    fill_im_r;
    logic [N_PTS-1:0][OUT_W-1:0]    hold_re_r;
    logic [N_PTS-1:0][OUT_W-1:0]    hold_im_r;
    logic                           out_valid_r;
    logic                           sat_pulse_r;
    logic                           sof_err_r;
    logic [15:0]                    frame_cnt_r;

    logic                           in_ready_s;
    logic                           accept_s;
    logic                           load_s;
    logic                           sof_err_s;
    logic [AW-1:0]                  wr_idx_s;
    logic [AW-1:0]                  widx_nxt_s;
    logic [AW-1:0]                  slot_s;
    logic                           sat_x_s;
    logic                           sat_y_s;
    logic [OUT_W-1:0]               x_s;
    logic [OUT_W-1:0]               y_s;
    logic [N_PTS-1:0][OUT_W-1:0]    merged_re_s;
    logic [N_PTS-1:0][OUT_W-1:0]    merged_im_s;

    // Handshake, slot addressing, scaling and the completed-frame image.
    always_comb begin
        in_ready_s = !((widx_r == LAST_IDX) && out_valid_r && !out_ready);
        accept_s   = in_valid && in_ready_s;
        if (in_sof) begin
            wr_idx_s   = {AW{1'b0}};
            widx_nxt_s = AW'(1);
        end else begin
            wr_idx_s   = widx_r;
            widx_nxt_s = widx_r + AW'(1);
        end
        if (BITREV != 0) begin
            slot_s = bit_rev(wr_idx_s);
        end else begin
            slot_s = wr_idx_s;
        end
        load_s    = accept_s && !in_sof && (widx_r == LAST_IDX);
        sof_err_s = accept_s && in_sof && (widx_r != {AW{1'b0}});
        {sat_x_s, x_s} = scale_sat(in_x);
        {sat_y_s, y_s} = scale_sat(in_y);
        merged_re_s         = fill_re_r;
        merged_im_s         = fill_im_r;
        merged_re_s[slot_s] = x_s;
        merged_im_s[slot_s] = y_s;
    end

    // Fill buffer and write index; an early SOF simply restarts at slot 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            widx_r    <= {AW{1'b0}};
            fill_re_r <= '{default: {OUT_W{1'b0}}};
            fill_im_r <= '{default: {OUT_W{1'b0}}};
        end else if (accept_s) begin
            widx_r    <= widx_nxt_s;
            fill_re_r <= merged_re_s;
            fill_im_r <= merged_im_s;
        end else begin
            widx_r    <= widx_r;
        end
    end

    // Hold register, frame handshake, frame counter and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_re_r   <= '{default: {OUT_W{1'b0}}};
            hold_im_r   <= '{default: {OUT_W{1'b0}}};
            out_valid_r <= 1'b0;
            frame_cnt_r <= 16'd0;
            sat_pulse_r <= 1'b0;
            sof_err_r   <= 1'b0;
        end else begin
            if (load_s) begin
                hold_re_r   <= merged_re_s;
                hold_im_r   <= merged_im_s;
                out_valid_r <= 1'b1;
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            sat_pulse_r <= accept_s && (sat_x_s || sat_y_s);
            sof_err_r   <= sof_err_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign frame_real = hold_re_r;
    assign frame_imag = hold_im_r;
    assign out_valid  = out_valid_r;
    assign sat_pulse  = sat_pulse_r;
    assign sof_err    = sof_err_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_frame_gather.sv
// Bench for frame_gather: a queue-based frame model checks a BITREV=0 and a
// BITREV=1 instance driven by the same stimulus.
module tb_frame_gather;

    localparam int N  = 8;
    localparam int W  = 24;
    localparam int FW = N * W;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_x, in_y;
    logic          in_valid, in_sof, out_ready;
    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic          sat0, sat1, serr0, serr1;
    logic [FW-1:0] fr0, fi0, fr1, fi1;
    logic [15:0]   cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    longint q_re[$];
    longint q_im[$];
    longint m_re[N];
    longint m_im[N];
    bit     m_valid, m_sat, m_serr;
    int     m_cnt;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] ex;
        logic [W-1:0] ey;
        bit           es;
    } vec_t;
    vec_t tbl[N];

    always #5 clk = ~clk;

    frame_gather #(.N_PTS(N), .IN_W(W), .OUT_W(W), .SHIFT(12), .BITREV(0)) dut0 (
        .clk(clk), .reset(reset), .in_x(in_x), .in_y(in_y), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready0), .frame_real(fr0), .frame_imag(fi0),
        .out_valid(out_valid0), .out_ready(out_ready), .sat_pulse(sat0),
        .sof_err(serr0), .frame_cnt(cnt0));

    frame_gather #(.N_PTS(N), .IN_W(W), .OUT_W(W), .SHIFT(12), .BITREV(1)) dut1 (
        .clk(clk), .reset(reset), .in_x(in_x), .in_y(in_y), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready1), .frame_real(fr1), .frame_imag(fi1),
        .out_valid(out_valid1), .out_ready(out_ready), .sat_pulse(sat1),
        .sof_err(serr1), .frame_cnt(cnt1));

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint scale(input logic [W-1:0] v, output bit s);
        longint r;
        r = longint'($signed(v)) * 64'sd4096;
        s = 1'b0;
        if (r > 64'sd8388607) begin
            r = 64'sd8388607;
            s = 1'b1;
        end else if (r < -64'sd8388608) begin
            r = -64'sd8388608;
            s = 1'b1;
        end
        return r;
    endfunction

    function automatic int brev(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    task automatic model_reset();
        q_re.delete();
        q_im.delete();
        for (int k = 0; k < N; k++) begin
            m_re[k] = 0;
            m_im[k] = 0;
        end
        m_valid = 1'b0;
        m_sat   = 1'b0;
        m_serr  = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        logic [FW-1:0] er0, ei0, er1, ei1;
        for (int k = 0; k < N; k++) begin
            er0[k*W +: W]       = W'(m_re[k]);
            ei0[k*W +: W]       = W'(m_im[k]);
            er1[brev(k)*W +: W] = W'(m_re[k]);
            ei1[brev(k)*W +: W] = W'(m_im[k]);
        end
        chk("out_valid0", out_valid0, m_valid);
        chk("out_valid1", out_valid1, m_valid);
        chk("frame_cnt0", cnt0, 16'(m_cnt));
        chk("frame_cnt1", cnt1, 16'(m_cnt));
        chk("sat_pulse0", sat0, m_sat);
        chk("sat_pulse1", sat1, m_sat);
        chk("sof_err0", serr0, m_serr);
        chk("sof_err1", serr1, m_serr);
        chk("frame_real0", fr0, er0);
        chk("frame_imag0", fi0, ei0);
        chk("frame_real1", fr1, er1);
        chk("frame_imag1", fi1, ei1);
    endtask

    // One clock: drive at the low phase, check in_ready, step model and DUT, check outputs.
    task automatic cycle(input bit v, input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit ordy, output bit acc);
        bit     exp_rdy, sx, sy, load;
        longint rx, ry;
        in_valid  = v;
        in_sof    = s;
        in_x      = x;
        in_y      = y;
        out_ready = ordy;
        exp_rdy = !((q_re.size() == N - 1) && m_valid && !ordy);
        #1;
        chk("in_ready0", in_ready0, exp_rdy);
        chk("in_ready1", in_ready1, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        m_sat  = 1'b0;
        m_serr = 1'b0;
        load   = 1'b0;
        if (acc) begin
            rx = scale(x, sx);
            ry = scale(y, sy);
            m_sat = sx | sy;
            if (s) begin
                if (q_re.size() != 0) m_serr = 1'b1;
                q_re.delete();
                q_im.delete();
            end
            q_re.push_back(rx);
            q_im.push_back(ry);
            if (q_re.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    m_re[k] = q_re[k];
                    m_im[k] = q_im[k];
                end
                q_re.delete();
                q_im.delete();
                m_cnt++;
                load = 1'b1;
            end
        end
        if (load) m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready0, 1'b1);
    endtask

    initial begin
        bit acc;
        int j;
        tbl[0] = '{24'd1,       24'hFFFFFF, 24'h001000, 24'hFFF000, 1'b0};
        tbl[1] = '{24'd2048,    24'hFFF800, 24'h7FFFFF, 24'h800000, 1'b1};
        tbl[2] = '{24'd2047,    24'hFFF800, 24'h7FF000, 24'h800000, 1'b0};
        tbl[3] = '{24'hFFF7FF,  24'd0,      24'h800000, 24'h000000, 1'b1};
        tbl[4] = '{24'd0,       24'd0,      24'h000000, 24'h000000, 1'b0};
        tbl[5] = '{24'h7FFFFF,  24'h800000, 24'h7FFFFF, 24'h800000, 1'b1};
        tbl[6] = '{24'd1000,    24'hFFFC18, 24'h3E8000, 24'hC18000, 1'b0};
        tbl[7] = '{24'hFFFFFF,  24'd1,      24'hFFF000, 24'h001000, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
        in_x = '0; in_y = '0;
        @(negedge clk);
        do_reset();

        // Basic frame: x=k+1, y=-(k+1).
        for (int k = 0; k < N; k++) cycle(1'b1, k == 0, W'(k + 1), W'(-(k + 1)), 1'b1, acc);
        chk("basic_cnt", cnt0, 16'd1);
        chk("basic_slot2_re", fr0[2*W +: W], 24'd12288);
        chk("basic_slot2_im", fi0[2*W +: W], 24'hFFD000);
        chk("bitrev_slot1_re", fr1[1*W +: W], 24'd20480);
        chk("bitrev_slot6_re", fr1[6*W +: W], 24'd16384);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);

        // Table of scaling / saturation vectors forming one frame.
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, i == 0, tbl[i].x, tbl[i].y, 1'b1, acc);
            chk("tbl_sat", sat0, tbl[i].es);
        end
        for (int i = 0; i < N; i++) begin
            chk("tbl_re", fr0[i*W +: W], tbl[i].ex);
            chk("tbl_im", fi0[i*W +: W], tbl[i].ey);
            chk("tbl_rev_re", fr1[brev(i)*W +: W], tbl[i].ex);
        end
        cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);

        // Backpressure: 16 continuous samples with out_ready low, then released.
        do_reset();
        j = 0;
        for (int c = 0; c < 40 && j < 16; c++) begin
            if (c == 19) chk("bp_stall_ready", in_ready0, 1'b0);
            cycle(1'b1, j == 0, W'(j + 1), W'(j * 3), c >= 20, acc);
            if (acc) j++;
        end
        chk("bp_all_accepted", j, 16);
        chk("bp_cnt", cnt0, 16'd2);
        chk("bp_second_slot7", fr0[7*W +: W], 24'd65536);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);

        // Early SOF after three samples.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b1, k == 0, W'(k + 7), W'(k), 1'b1, acc);
        cycle(1'b1, 1'b1, 24'd100, 24'd200, 1'b1, acc);
        chk("sof_err_pulse", serr0, 1'b1);
        for (int k = 1; k < N; k++) cycle(1'b1, 1'b0, W'(100 + k), W'(k), 1'b1, acc);
        chk("sof_cnt", cnt0, 16'd1);
        chk("sof_out_valid", out_valid0, 1'b1);

        // Reset in the middle of a frame with a frame held.
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, W'(k + 50), W'(k), 1'b0, acc);
        do_reset();
        chk("mid_rst_hold", fr0, {FW{1'b0}});
        for (int k = 0; k < N; k++) cycle(1'b1, 1'b0, W'(k + 9), W'(k + 1), 1'b1, acc);
        chk("mid_rst_cnt", cnt0, 16'd1);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [W-1:0] rx, ry;
            if ($urandom_range(0, 1) == 0) begin
                rx = W'(int'($urandom_range(0, 4095)) - 2048);
                ry = W'(int'($urandom_range(0, 4095)) - 2048);
            end else begin
                rx = W'($urandom);
                ry = W'($urandom);
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rx, ry,
                  $urandom_range(0, 2) != 0, acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
